// File: rtl/systolic_pkg.sv
// Shared constants, FSM encoding and an element-address helper for the
// 4x4 systolic feed controller.
package systolic_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int N              = 4;
    localparam int FEED_STEPS     = 2 * N - 1;
    localparam int STEP_W         = 3;
    localparam int ADDR_W         = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_FEED  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // Flat bank index of element [row][col]: {row[1:0], col[1:0]}.
    function automatic logic [ADDR_W-1:0] elem_addr(input int row, input int col);
        return ADDR_W'(row * N + col);
    endfunction

endpackage

// File: rtl/systolic_feed_ctrl_if.sv
// Operand write bus: one strobe, bank select, element index and data.
interface systolic_feed_ctrl_if #(
    parameter int DATA_WIDTH = systolic_pkg::DEF_DATA_WIDTH
);
    logic                  wr_en;
    logic                  wr_sel;
    logic [3:0]            wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;

    modport master (output wr_en, wr_sel, wr_addr, wr_data);
    modport slave  (input  wr_en, wr_sel, wr_addr, wr_data);
endinterface

// File: rtl/systolic_operand_rf.sv
// Two 16-entry operand banks (A and B) with a single write port and
// combinational visibility of every element.
module systolic_operand_rf
    import systolic_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk_i,
    systolic_feed_ctrl_if.slave   wr,
    output logic [DATA_WIDTH-1:0] a_q [N*N],
    output logic [DATA_WIDTH-1:0] b_q [N*N]
);

    // Store one element into the selected bank when the write strobe is high.
    // NOTE: the banks have no reset -- contents are only meaningful once
    // written, and leaving storage unreset keeps it a plain register file.
    // Sequential state is always assigned with <= so every register samples
    // pre-edge values.
    always_ff @(posedge clk_i) begin
        if (wr.wr_en) begin
            if (wr.wr_sel) begin
                b_q[wr.wr_addr] <= wr.wr_data;
            end else begin
                a_q[wr.wr_addr] <= wr.wr_data;
            end
        end
    end

endmodule

// File: rtl/systolic_feed_ctrl.sv
// Feed controller for a 4x4 output-stationary systolic array: clears the
// accumulators, streams skewed A rows / B columns for 7 steps, waits for the
// array to drain, then pulses done.
module systolic_feed_ctrl
    import systolic_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  wr_en_i,
    input  logic                  wr_sel_i,
    input  logic [3:0]            wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  start_i,
    output logic [DATA_WIDTH-1:0] left_o_0,
    output logic [DATA_WIDTH-1:0] left_o_1,
    output logic [DATA_WIDTH-1:0] left_o_2,
    output logic [DATA_WIDTH-1:0] left_o_3,
    output logic [DATA_WIDTH-1:0] up_o_0,
    output logic [DATA_WIDTH-1:0] up_o_1,
    output logic [DATA_WIDTH-1:0] up_o_2,
    output logic [DATA_WIDTH-1:0] up_o_3,
    output logic                  array_rst_no,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam int DRAIN_W    = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam int DRAIN_LOAD = (DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0;

    state_e                state_q, state_d;
    logic [STEP_W-1:0]     step_q, step_d;
    logic [DRAIN_W-1:0]    drain_q, drain_d;
    logic                  array_rst_q;

    logic [DATA_WIDTH-1:0] a_q    [N*N];
    logic [DATA_WIDTH-1:0] b_q    [N*N];
    logic [DATA_WIDTH-1:0] left_d [N];
    logic [DATA_WIDTH-1:0] up_d   [N];
    logic [DATA_WIDTH-1:0] left_q [N];
    logic [DATA_WIDTH-1:0] up_q   [N];

    // Writes are accepted only while idle; anything arriving mid-run is dropped.
    systolic_feed_ctrl_if #(.DATA_WIDTH(DATA_WIDTH)) wr_bus ();

    assign wr_bus.wr_en   = wr_en_i & (state_q == ST_IDLE);
    assign wr_bus.wr_sel  = wr_sel_i;
    assign wr_bus.wr_addr = wr_addr_i;
    assign wr_bus.wr_data = wr_data_i;

    systolic_operand_rf #(.DATA_WIDTH(DATA_WIDTH)) u_rf (
        .clk_i (clk_i),
        .wr    (wr_bus),
        .a_q   (a_q),
        .b_q   (b_q)
    );

    // Next-state and step/drain counter logic.
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        drain_d = drain_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start_i) state_d = ST_CLEAR;
            end
            ST_CLEAR: begin
                state_d = ST_FEED;
                step_d  = '0;
            end
            ST_FEED: begin
                if (step_q == STEP_W'(FEED_STEPS - 1)) begin
                    if (DRAIN_CYCLES == 0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_DRAIN;
                        drain_d = DRAIN_W'(DRAIN_LOAD);
                    end
                end else begin
                    step_d = step_q + STEP_W'(1);
                end
            end
            ST_DRAIN: begin
                if (drain_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    drain_d = drain_q - DRAIN_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                step_d  = '0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Skewed edge data for the step being entered: row r lags by r, column c by c.
    always_comb begin
        for (int r = 0; r < N; r++) begin
            left_d[r] = '0;
            up_d[r]   = '0;
        end
        if (state_d == ST_FEED) begin
            for (int r = 0; r < N; r++) begin
                if (int'(step_d) >= r && int'(step_d) - r < N) begin
                    left_d[r] = a_q[elem_addr(r, int'(step_d) - r)];
                    up_d[r]   = b_q[elem_addr(int'(step_d) - r, r)];
                end
            end
        end
    end

    // FSM state and counters.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            step_q  <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            drain_q <= drain_d;
        end
    end

    // Registered array-facing outputs, so each step's data holds a full cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            array_rst_q <= 1'b0;
            for (int r = 0; r < N; r++) begin
                left_q[r] <= '0;
                up_q[r]   <= '0;
            end
        end else begin
            array_rst_q <= (state_d != ST_CLEAR);
            for (int r = 0; r < N; r++) begin
                left_q[r] <= left_d[r];
                up_q[r]   <= up_d[r];
            end
        end
    end

    assign left_o_0     = left_q[0];
    assign left_o_1     = left_q[1];
    assign left_o_2     = left_q[2];
    assign left_o_3     = left_q[3];
    assign up_o_0       = up_q[0];
    assign up_o_1       = up_q[1];
    assign up_o_2       = up_q[2];
    assign up_o_3       = up_q[3];
    assign array_rst_no = array_rst_q;
    assign busy_o       = (state_q != ST_IDLE);
    assign done_o       = (state_q == ST_DONE);

endmodule

// File: tb/tb_systolic_feed_ctrl.sv
// Bench for systolic_feed_ctrl: per-step feed vectors from a table, done
// timing through a scoreboard queue, and a behavioural 4x4 array on the
// outputs to confirm the final products.
module tb_systolic_feed_ctrl;
    import systolic_pkg::*;

    localparam int DW    = 32;
    localparam int DRAIN = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    always #5 clk = ~clk;

    systolic_feed_ctrl_if #(.DATA_WIDTH(DW)) wr ();

    logic [DW-1:0] left_o_0, left_o_1, left_o_2, left_o_3;
    logic [DW-1:0] up_o_0, up_o_1, up_o_2, up_o_3;
    logic          array_rst_n, busy, done;

    systolic_feed_ctrl #(.DATA_WIDTH(DW), .DRAIN_CYCLES(DRAIN)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .wr_en_i      (wr.wr_en),
        .wr_sel_i     (wr.wr_sel),
        .wr_addr_i    (wr.wr_addr),
        .wr_data_i    (wr.wr_data),
        .start_i      (start),
        .left_o_0     (left_o_0),
        .left_o_1     (left_o_1),
        .left_o_2     (left_o_2),
        .left_o_3     (left_o_3),
        .up_o_0       (up_o_0),
        .up_o_1       (up_o_1),
        .up_o_2       (up_o_2),
        .up_o_3       (up_o_3),
        .array_rst_no (array_rst_n),
        .busy_o       (busy),
        .done_o       (done)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    wire [127:0] lefts_p = {left_o_3, left_o_2, left_o_1, left_o_0};
    wire [127:0] ups_p   = {up_o_3, up_o_2, up_o_1, up_o_0};

    // ---------------- golden operands and feed table ----------------
    logic [DW-1:0] ga [4][4];
    logic [DW-1:0] gb [4][4];

    typedef struct {
        int           step;
        logic [127:0] left;
        logic [127:0] up;
    } vec_t;
    vec_t vecs [FEED_STEPS];

    function automatic logic [127:0] exp_left(input int k);
        logic [127:0] v = '0;
        for (int r = 0; r < 4; r++)
            if (k - r >= 0 && k - r <= 3) v[r*32 +: 32] = ga[r][k-r];
        return v;
    endfunction

    function automatic logic [127:0] exp_up(input int k);
        logic [127:0] v = '0;
        for (int c = 0; c < 4; c++)
            if (k - c >= 0 && k - c <= 3) v[c*32 +: 32] = gb[k-c][c];
        return v;
    endfunction

    task automatic fill_vecs();
        for (int k = 0; k < FEED_STEPS; k++) begin
            vecs[k].step = k;
            vecs[k].left = exp_left(k);
            vecs[k].up   = exp_up(k);
        end
    endtask

    // ---------------- behavioural systolic array ----------------
    logic [DW-1:0] lefts [4];
    logic [DW-1:0] ups   [4];
    logic [DW-1:0] a_pe  [4][4];
    logic [DW-1:0] b_pe  [4][4];
    logic [DW-1:0] acc   [4][4];
    logic [DW-1:0] a_in  [4][4];
    logic [DW-1:0] b_in  [4][4];

    assign lefts[0] = left_o_0;
    assign lefts[1] = left_o_1;
    assign lefts[2] = left_o_2;
    assign lefts[3] = left_o_3;
    assign ups[0]   = up_o_0;
    assign ups[1]   = up_o_1;
    assign ups[2]   = up_o_2;
    assign ups[3]   = up_o_3;

    always_comb begin
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                a_in[i][j] = (j == 0) ? lefts[i] : a_pe[i][(j == 0) ? 0 : j - 1];
                b_in[i][j] = (i == 0) ? ups[j]   : b_pe[(i == 0) ? 0 : i - 1][j];
            end
    end

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                if (!array_rst_n) begin
                    a_pe[i][j] <= '0;
                    b_pe[i][j] <= '0;
                    acc[i][j]  <= '0;
                end else begin
                    a_pe[i][j] <= a_in[i][j];
                    b_pe[i][j] <= b_in[i][j];
                    acc[i][j]  <= acc[i][j] + a_in[i][j] * b_in[i][j];
                end
    end

    // ---------------- done scoreboard ----------------
    int done_q    [$];
    int done_seen [$];

    always @(negedge clk) begin
        if (rst_n && done) begin
            done_seen.push_back(cyc);
            check("done_expected", 128'(done_q.size() != 0), 128'(1));
            if (done_q.size() != 0) check("done_cycle", 128'(cyc), 128'(done_q.pop_front()));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic write_elem(input logic sel, input int row, input int col, input logic [DW-1:0] data);
        wr.wr_en   = 1'b1;
        wr.wr_sel  = sel;
        wr.wr_addr = 4'(row * 4 + col);
        wr.wr_data = data;
        @(negedge clk);
        wr.wr_en   = 1'b0;
    endtask

    task automatic load_banks();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                ga[r][c] = DW'(4 * r + c + 1);
                gb[r][c] = DW'(c + 1);
                write_elem(1'b0, r, c, ga[r][c]);
                write_elem(1'b1, r, c, gb[r][c]);
            end
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // One full run starting from an idle negedge; optionally pokes a write and
    // a second start at feed step 2, both of which must be ignored.
    task automatic run_check(input bit inject);
        int c0;
        fill_vecs();
        c0 = cyc;
        start = 1'b1;
        done_q.push_back(c0 + 13);
        @(negedge clk);
        start = 1'b0;
        check("clear_busy", 128'(busy), 128'(1));
        check("clear_arst", 128'(array_rst_n), 128'(0));
        check("clear_outs", {lefts_p ^ ups_p, lefts_p | ups_p} != 0 ? 128'(1) : 128'(0), 128'(0));
        @(negedge clk);
        for (int k = 0; k < FEED_STEPS; k++) begin
            check($sformatf("feed%0d_left", vecs[k].step), lefts_p, vecs[k].left);
            check($sformatf("feed%0d_up", vecs[k].step), ups_p, vecs[k].up);
            if (k == 0) check("feed_arst", 128'(array_rst_n), 128'(1));
            if (inject && k == 2) begin
                wr.wr_en   = 1'b1;
                wr.wr_sel  = 1'b0;
                wr.wr_addr = 4'd0;
                wr.wr_data = DW'(99);
                start      = 1'b1;
            end
            @(negedge clk);
            wr.wr_en = 1'b0;
            start    = 1'b0;
        end
        for (int d = 0; d < DRAIN; d++) begin
            check("drain_outs", lefts_p | ups_p, 128'(0));
            check("drain_done", 128'(done), 128'(0));
            @(negedge clk);
        end
        check("done_pulse", 128'(done), 128'(1));
        check("done_busy", 128'(busy), 128'(1));
        @(negedge clk);
        check("idle_busy", 128'(busy), 128'(0));
        check("idle_done", 128'(done), 128'(0));
    endtask

    task automatic check_array();
        logic [DW-1:0] e;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                e = '0;
                for (int k = 0; k < 4; k++) e += ga[i][k] * gb[k][j];
                check($sformatf("c%0d%0d", i, j), 128'(acc[i][j]), 128'(e));
            end
        check("c00_const", 128'(acc[0][0]), 128'(10));
        check("c33_const", 128'(acc[3][3]), 128'(232));
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int c0;
        wr.wr_en   = 1'b0;
        wr.wr_sel  = 1'b0;
        wr.wr_addr = '0;
        wr.wr_data = '0;

        // Reset values.
        wait_cycles(2);
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_done", 128'(done), 128'(0));
        check("rst_arst", 128'(array_rst_n), 128'(0));
        check("rst_outs", lefts_p | ups_p, 128'(0));
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_arst", 128'(array_rst_n), 128'(1));
        check("rel_busy", 128'(busy), 128'(0));

        // Basic run with spec data, timing and array products.
        load_banks();
        fill_vecs();
        check("tbl_s0_left", vecs[0].left, 128'(1));
        check("tbl_s6_up", vecs[6].up, {32'd4, 96'd0});
        run_check(1'b0);
        check_array();

        // Write and start during FEED are dropped; bank checked by next run.
        run_check(1'b1);
        wait_cycles(3);
        run_check(1'b0);
        check("single_done_after_inject", 128'(done_q.size()), 128'(0));

        // Reset at FEED step 3 aborts immediately.
        c0 = cyc;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_cycles(4);
        check("pre_rst_step3", lefts_p, vecs[3].left);
        #1 rst_n = 1'b0;
        #1;
        check("abort_outs", lefts_p | ups_p, 128'(0));
        check("abort_busy", 128'(busy), 128'(0));
        check("abort_arst", 128'(array_rst_n), 128'(0));
        check("abort_done", 128'(done), 128'(0));
        wait_cycles(3);
        rst_n = 1'b1;
        wait_cycles(16);
        check("abort_no_done", 128'(done_seen.size() > 0 && done_seen[done_seen.size()-1] > c0), 128'(0));
        load_banks();
        run_check(1'b0);
        check_array();

        // Continuous start: back-to-back runs 14 cycles apart.
        done_seen.delete();
        c0 = cyc;
        start = 1'b1;
        done_q.push_back(c0 + 13);
        done_q.push_back(c0 + 27);
        done_q.push_back(c0 + 41);
        wait_cycles(42);
        start = 1'b0;
        wait_cycles(16);
        check("b2b_count", 128'(done_seen.size()), 128'(3));
        if (done_seen.size() >= 3) begin
            check("b2b_gap0", 128'(done_seen[1] - done_seen[0]), 128'(14));
            check("b2b_gap1", 128'(done_seen[2] - done_seen[1]), 128'(14));
        end
        check("b2b_idle", 128'(busy), 128'(0));
        check("sb_empty", 128'(done_q.size()), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
